multicycle_cu: RTL and testbench

- Multi-cycle sequencer for the 16-bit CPU datapath.
- Steps every instruction through FETCH, DECODE, EXEC, MEM and WB.
- Arbitrates the single shared memory port between instruction fetch and data access, and drives every datapath control strobe from its state register.
- Sits between the instruction/data memory and the register file/ALU/PC datapath.

---
 rtl/multicycle_cu.sv | 108 ++++++++++
 tb/tb_multicycle_cu.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
// multicycle_cu: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit CPU datapath
//   Clock, Reset (sync, active-high), Run (level start/stop at instruction boundary)
//   Opcode  : instruction bits [15:14], latched in FETCH on MemReady
//   MemReady: memory handshake; MemReq/MemInstr/MemRead/MemWrite drive the shared port
//   IRWrite/PCWrite pulse on the completing fetch cycle; other strobes are registered
//   Busy = not IDLE, Err = sticky memory timeout, RetireCnt = completed instructions
module multicycle_cu #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Run,
  input  logic [1:0]       Opcode,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemInstr,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             ALUOp,
  output logic             Busy,
  output logic             Err,
  output logic [CNT_W-1:0] RetireCnt
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;
  state_t state, nState;
  logic [1:0] op, nOp;
  logic [WW-1:0] waitCnt, nWait;
  logic [8:0] ctl;
  logic nErr, done, timeout;
  // strobe vector {MemReq,MemInstr,MemRead,MemWrite,RegDst,ALUSrc,MemToReg,RegWrite,ALUOp};
  // a memory state whose wait counter has hit the limit issues nothing
  function automatic logic [8:0] ctlOf(state_t s, logic [1:0] o, logic to);
    ctlOf = '0;
    if (!to)
      case (s)
        FETCH:   ctlOf = 9'b1110_00000;
        EXEC:    ctlOf = {4'b0000, 1'b0, o != 2'd0, 1'b0, 1'b0, o == 2'd0};
        MEM:     ctlOf = {1'b1, 1'b0, o == 2'd2, o == 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        WB:      ctlOf = {4'b0000, o == 2'd0, o == 2'd1, o == 2'd2, 1'b1, o == 2'd0};
        default: ctlOf = '0;
      endcase
  endfunction
  always_comb begin
    nState  = state;
    nOp     = op;
    nErr    = Err;
    done    = 1'b0;
    timeout = waitCnt == WW'(WAIT_MAX);
    case (state)
      IDLE:   nState = (Run && !Err) ? FETCH : IDLE;
      FETCH: begin
        if (timeout) begin
          nState = IDLE;
          nErr   = 1'b1;
        end else if (MemReady) begin
          nState = DECODE;
          nOp    = Opcode;
        end
      end
      DECODE: nState = EXEC;
      EXEC:   nState = op[1] ? MEM : WB;
      MEM: begin
        if (timeout) begin
          nState = IDLE;
          nErr   = 1'b1;
        end else if (MemReady) begin
          done   = op == 2'd3;
          nState = WB;
        end
      end
      WB:      done = 1'b1;
      default: nState = IDLE;
    endcase
    if (done) nState = Run ? FETCH : IDLE;
    // any state change (notably entry to FETCH or MEM) restarts the wait count
    nWait = (nState != state) ? '0 : waitCnt + WW'(MemReq && !MemReady);
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      op        <= 2'd0;
      waitCnt   <= '0;
      Err       <= 1'b0;
      RetireCnt <= '0;
      ctl       <= '0;
    end else begin
      state     <= nState;
      op        <= nOp;
      waitCnt   <= nWait;
      Err       <= nErr;
      RetireCnt <= RetireCnt + CNT_W'(done);
      ctl       <= ctlOf(nState, nOp, nWait == WW'(WAIT_MAX));
    end
  end
  assign {MemReq, MemInstr, MemRead, MemWrite, RegDst, ALUSrc, MemToReg, RegWrite, ALUOp} = ctl;
  // only the fetch handshake cycle loads IR and advances PC
  assign IRWrite = MemReq && MemInstr && MemReady;
  assign PCWrite = IRWrite;
  assign Busy    = state != IDLE;
endmodule

// File: tb/tb_multicycle_cu.sv
// tb_multicycle_cu: directed self-checking bench for multicycle_cu
module tb_multicycle_cu;
  logic Clock = 1'b0, Reset = 1'b1, Run = 1'b0, MemReady = 1'b0;
  logic [1:0] Opcode = 2'd0;
  logic MemReq, MemInstr, MemRead, MemWrite, IRWrite, PCWrite, RegDst, ALUSrc, MemToReg, RegWrite, ALUOp, Busy, Err;
  logic [15:0] RetireCnt;
  logic b_MemReq, b_MemInstr, b_MemRead, b_MemWrite, b_IRWrite, b_PCWrite, b_RegDst, b_ALUSrc, b_MemToReg, b_RegWrite, b_ALUOp, b_Busy, b_Err;
  logic [3:0] b_RetireCnt;
  logic [11:0] sig;
  int tests = 0, fails = 0;
  localparam logic [11:0] S_IDLE = 12'h000, S_FW = 12'hE01, S_FR = 12'hEC1, S_DEC = 12'h001,
    S_EXR = 12'h003, S_EXI = 12'h011, S_MLW = 12'hA11, S_MSW = 12'h911,
    S_WBR = 12'h027, S_WBI = 12'h015, S_WBL = 12'h00D;
  always #5 Clock = ~Clock;
  multicycle_cu dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Opcode(Opcode), .MemReady(MemReady),
    .MemReq(MemReq), .MemInstr(MemInstr), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegDst(RegDst), .ALUSrc(ALUSrc),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUOp(ALUOp), .Busy(Busy), .Err(Err),
    .RetireCnt(RetireCnt)
  );
  multicycle_cu #(.CNT_W(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Opcode(Opcode), .MemReady(MemReady),
    .MemReq(b_MemReq), .MemInstr(b_MemInstr), .MemRead(b_MemRead), .MemWrite(b_MemWrite),
    .IRWrite(b_IRWrite), .PCWrite(b_PCWrite), .RegDst(b_RegDst), .ALUSrc(b_ALUSrc),
    .MemToReg(b_MemToReg), .RegWrite(b_RegWrite), .ALUOp(b_ALUOp), .Busy(b_Busy), .Err(b_Err),
    .RetireCnt(b_RetireCnt)
  );
  assign sig = {MemReq, MemInstr, MemRead, MemWrite, IRWrite, PCWrite, RegDst, ALUSrc, MemToReg, RegWrite, ALUOp, Busy};
  task automatic step();
    @(posedge Clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // runs one instruction with MemReady high, starting in its FETCH cycle
  task automatic doInstr(input logic [1:0] o, input logic keepRun);
    Opcode = o;
    chk("fetch", 32'(sig), 32'(S_FR));
    step();
    Opcode = ~o;
    Run = keepRun;
    chk("decode", 32'(sig), 32'(S_DEC));
    step();
    chk("exec", 32'(sig), 32'(o == 2'd0 ? S_EXR : S_EXI));
    step();
    if (o[1]) begin
      chk("mem", 32'(sig), 32'(o == 2'd2 ? S_MLW : S_MSW));
      step();
    end
    if (o != 2'd3) begin
      chk("wb", 32'(sig), 32'(o == 2'd0 ? S_WBR : (o == 2'd1 ? S_WBI : S_WBL)));
      step();
    end
  endtask
  initial begin
    step();
    step();
    Reset = 1'b0;
    step();
    chk("reset_sig", 32'(sig), 32'(S_IDLE));
    chk("reset_err", 32'(Err), 32'd0);
    chk("reset_cnt", 32'(RetireCnt), 32'd0);
    // back-to-back R, addi, LW, SW
    Run = 1'b1;
    MemReady = 1'b1;
    step();
    doInstr(2'd0, 1'b1);
    chk("cnt_after_r", 32'(RetireCnt), 32'd1);
    doInstr(2'd1, 1'b1);
    doInstr(2'd2, 1'b1);
    chk("cnt_after_lw", 32'(RetireCnt), 32'd3);
    doInstr(2'd3, 1'b0);
    chk("b2b_idle", 32'(sig), 32'(S_IDLE));
    chk("b2b_cnt", 32'(RetireCnt), 32'd4);
    chk("b2b_cnt4", 32'(b_RetireCnt), 32'd4);
    // fetch stalled three cycles
    Run = 1'b1;
    MemReady = 1'b0;
    Opcode = 2'd1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("fetch_wait", 32'(sig), 32'(S_FW));
      step();
    end
    chk("fetch_wait4", 32'(sig), 32'(S_FW));
    MemReady = 1'b1;
    #1;
    chk("fetch_pulse", 32'(sig), 32'(S_FR));
    Run = 1'b0;
    step();
    chk("fetch_dec", 32'(sig), 32'(S_DEC));
    step();
    chk("fetch_exec", 32'(sig), 32'(S_EXI));
    step();
    chk("fetch_wb", 32'(sig), 32'(S_WBI));
    step();
    chk("fetch_idle", 32'(sig), 32'(S_IDLE));
    chk("fetch_cnt", 32'(RetireCnt), 32'd5);
    // 15 waits in MEM of SW -> timeout
    Run = 1'b1;
    Opcode = 2'd3;
    step();
    step();
    step();
    MemReady = 1'b0;
    step();
    for (int i = 0; i < 15; i++) begin
      chk("to_mem", 32'(sig), 32'(S_MSW));
      step();
    end
    chk("to_nostrobe", 32'(sig), 32'(S_DEC));
    chk("to_err_pre", 32'(Err), 32'd0);
    MemReady = 1'b1;
    step();
    chk("to_idle", 32'(sig), 32'(S_IDLE));
    chk("to_err", 32'(Err), 32'd1);
    step();
    step();
    chk("to_hold", 32'(sig), 32'(S_IDLE));
    chk("to_hold_err", 32'(Err), 32'd1);
    chk("to_cnt", 32'(RetireCnt), 32'd5);
    Run = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("to_clr_err", 32'(Err), 32'd0);
    chk("to_clr_cnt", 32'(RetireCnt), 32'd0);
    // 14 waits then ready -> completes
    Run = 1'b1;
    step();
    step();
    step();
    MemReady = 1'b0;
    step();
    for (int i = 0; i < 14; i++) begin
      chk("w14_mem", 32'(sig), 32'(S_MSW));
      step();
    end
    chk("w14_last", 32'(sig), 32'(S_MSW));
    MemReady = 1'b1;
    Run = 1'b0;
    step();
    chk("w14_idle", 32'(sig), 32'(S_IDLE));
    chk("w14_err", 32'(Err), 32'd0);
    chk("w14_cnt", 32'(RetireCnt), 32'd1);
    // Run dropped during EXEC of LW
    Run = 1'b1;
    Opcode = 2'd2;
    step();
    step();
    step();
    chk("drop_exec", 32'(sig), 32'(S_EXI));
    Run = 1'b0;
    step();
    chk("drop_mem", 32'(sig), 32'(S_MLW));
    step();
    chk("drop_wb", 32'(sig), 32'(S_WBL));
    step();
    chk("drop_idle", 32'(sig), 32'(S_IDLE));
    chk("drop_busy", 32'(Busy), 32'd0);
    chk("drop_cnt", 32'(RetireCnt), 32'd2);
    // 16 R-type: 4-bit counter wraps
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    Run = 1'b1;
    step();
    for (int k = 0; k < 16; k++) doInstr(2'd0, k != 15);
    chk("wrap_cnt4", 32'(b_RetireCnt), 32'd0);
    chk("wrap_cnt16", 32'(RetireCnt), 32'd16);
    // reset in MEM of SW mid-handshake
    Run = 1'b1;
    Opcode = 2'd3;
    step();
    step();
    step();
    MemReady = 1'b0;
    step();
    chk("rst_mem", 32'(sig), 32'(S_MSW));
    step();
    step();
    Reset = 1'b1;
    Run = 1'b0;
    step();
    Reset = 1'b0;
    chk("rst_sig", 32'(sig), 32'(S_IDLE));
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_cnt", 32'(RetireCnt), 32'd0);
    chk("rst_cnt4", 32'(b_RetireCnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
